axi_read_responder: RTL

Single-port AXI4 read-channel responder backed by a word-addressed memory array. It sits on the memory side of the shared AXI read bus and answers AR requests from the instruction and data caches with INCR, WRAP or FIXED bursts of 64-bit beats. It is the system-memory model used by every cache-level bench, and it is synthesizable.

---
 rtl/axi_read_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a word-addressed 64-bit memory.
// Serves one FIXED/INCR/WRAP burst at a time after a fixed read latency,
// flags SLVERR per burst and DECERR per beat, and has a preload write port.
module axi_read_responder #(
  parameter int MEM_WORDS    = 4096,
  parameter int ADDR_WIDTH   = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_arready,
  output logic                         s_axi_rvalid,
  output logic [63:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  input  logic                         s_axi_rready,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [63:0]                  load_data
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int WORD_W = ADDR_WIDTH - 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  logic [63:0]       mem [MEM_WORDS];

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [3:0]        lat_cnt;
  logic [WORD_W-1:0] base_word;
  logic [7:0]        burst_len;
  logic [1:0]        burst_type;
  logic              burst_slverr;
  logic [8:0]        beat_num;

  logic              handshake;
  logic              req_slverr;
  logic              present_beat;
  logic              finish_burst;

  logic [WORD_W-1:0] sel_word;
  logic [7:0]        sel_len;
  logic [1:0]        sel_type;
  logic              sel_slverr;
  logic [8:0]        sel_beat;

  logic [WORD_W-1:0] wrap_mask;
  logic [WORD_W-1:0] beat_sum;
  logic [WORD_W-1:0] beat_word;
  logic              beat_decerr;
  logic [1:0]        beat_resp;
  logic [63:0]       beat_data;
  logic              beat_last;

  // Byte-offset bits of the address are aligned away and never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^s_axi_araddr[2:0];

  assign handshake    = (state == ST_IDLE) && s_axi_arready && s_axi_arvalid;
  assign finish_burst = (state == ST_BURST) && s_axi_rvalid && s_axi_rready && s_axi_rlast;

  // Classify the incoming request: bad size, reserved burst, or illegal wrap length.
  always_comb begin
    req_slverr = 1'b0;
    if (s_axi_arsize != 3'd3) begin
      req_slverr = 1'b1;
    end else if (s_axi_arburst == 2'd3) begin
      req_slverr = 1'b1;
    end else if (s_axi_arburst == BURST_WRAP) begin
      req_slverr = !((s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                     (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15));
    end
  end

  // Pick burst context: the live request in IDLE (zero-latency first beat), latched copy otherwise.
  always_comb begin
    if (state == ST_IDLE) begin
      sel_word   = s_axi_araddr[ADDR_WIDTH-1:3];
      sel_len    = s_axi_arlen;
      sel_type   = s_axi_arburst;
      sel_slverr = req_slverr;
      sel_beat   = 9'd0;
    end else begin
      sel_word   = base_word;
      sel_len    = burst_len;
      sel_type   = burst_type;
      sel_slverr = burst_slverr;
      sel_beat   = beat_num;
    end
  end

  // Compute word index, response code, data and last flag for the beat about to be registered.
  always_comb begin
    wrap_mask = WORD_W'(sel_len);
    beat_sum  = sel_word + WORD_W'(sel_beat);
    case (sel_type)
      BURST_FIXED: beat_word = sel_word;
      BURST_INCR:  beat_word = beat_sum;
      BURST_WRAP:  beat_word = (sel_word & ~wrap_mask) | (beat_sum & wrap_mask);
      default:     beat_word = sel_word;
    endcase
    beat_decerr = (beat_word >= WORD_W'(MEM_WORDS));
    if (sel_slverr) begin
      beat_resp = RESP_SLVERR;
    end else if (beat_decerr) begin
      beat_resp = RESP_DECERR;
    end else begin
      beat_resp = RESP_OKAY;
    end
    beat_data = '0;
    if (beat_resp == RESP_OKAY) begin
      beat_data = mem[beat_word[IDX_W-1:0]];
    end
    beat_last = ({1'b0, sel_len} == sel_beat);
  end

  // Decide when a new beat is loaded into the output registers.
  always_comb begin
    present_beat = 1'b0;
    case (state)
      ST_IDLE:  present_beat = handshake && (READ_LATENCY == 0);
      ST_WAIT:  present_beat = (lat_cnt <= 4'd1);
      ST_BURST: present_beat = s_axi_rvalid && s_axi_rready && !s_axi_rlast;
      default:  present_beat = 1'b0;
    endcase
  end

  // Next-state logic for the IDLE -> WAIT -> BURST cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          next_state = (READ_LATENCY == 0) ? ST_BURST : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt <= 4'd1) begin
          next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        if (finish_burst) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register, latency counter and latched burst context.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ST_IDLE;
      lat_cnt      <= 4'd0;
      base_word    <= '0;
      burst_len    <= 8'd0;
      burst_type   <= 2'd0;
      burst_slverr <= 1'b0;
      beat_num     <= 9'd0;
    end else begin
      state <= next_state;
      if (handshake) begin
        base_word    <= s_axi_araddr[ADDR_WIDTH-1:3];
        burst_len    <= s_axi_arlen;
        burst_type   <= s_axi_arburst;
        burst_slverr <= req_slverr;
        lat_cnt      <= 4'(READ_LATENCY);
      end else if ((state == ST_WAIT) && (lat_cnt > 4'd1)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (present_beat) begin
        beat_num <= sel_beat + 9'd1;
      end else if (handshake) begin
        beat_num <= 9'd0;
      end
    end
  end

  // Registered AR ready and R channel outputs; held steady while the master stalls.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 64'd0;
      s_axi_rresp   <= 2'd0;
      s_axi_rlast   <= 1'b0;
    end else begin
      s_axi_arready <= (next_state == ST_IDLE);
      if (present_beat) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= beat_data;
        s_axi_rresp  <= beat_resp;
        s_axi_rlast  <= beat_last;
      end else if (finish_burst) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
    end
  end

  // Preload port; the array is deliberately left out of reset so contents persist.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule
